// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared geometry, mode encoding and blitter state types
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 40;
    localparam int SPRITE_H = 40;

    localparam logic MODE_SCREEN = 1'b0;
    localparam logic MODE_SPRITE = 1'b1;

    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - row-major col/row/address raster walk over a screen or sprite
module raster_counter
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic        mode_i,
    output logic [7:0]  col_o,
    output logic [6:0]  row_o,
    output logic [14:0] addr_o,
    output logic        last_o
);

    logic [7:0]  col_q, col_d;
    logic [6:0]  row_q, row_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  col_max;
    logic [6:0]  row_max;
    logic        col_end;
    logic        row_end;

    assign col_max = (mode_i == MODE_SPRITE) ? 8'(SPRITE_W - 1) : 8'(SCREEN_W - 1);
    assign row_max = (mode_i == MODE_SPRITE) ? 7'(SPRITE_H - 1) : 7'(SCREEN_H - 1);
    assign col_end = (col_q == col_max);
    assign row_end = (row_q == row_max);

    // Linear address just increments: row-major order makes it equal row*W+col.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (en_i) begin
            addr_d = addr_q + 15'd1;
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? 7'd0 : row_q + 7'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign addr_o = addr_q;
    assign last_o = col_end && row_end;

endmodule

// File: rtl/screen_blitter.sv
// rtl/screen_blitter.sv - rasters a screen or sprite from colour ROM into VGA plot writes
module screen_blitter #(
    parameter int                 ROM_LAT = 1,
    parameter int                 COLOR_W = 3,
    parameter logic [COLOR_W-1:0] KEY     = 3'b101
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               black,
    input  logic [7:0]         xInit,
    input  logic [6:0]         yInit,
    output logic [14:0]        romAddr,
    input  logic [COLOR_W-1:0] romData,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [COLOR_W-1:0] colour,
    output logic               plot,
    output logic               busy,
    output logic               done
);
    import game_pkg::*;

    localparam int L = ROM_LAT - 1;

    blit_state_t state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic        mode_q;
    logic        black_q;
    logic [7:0]  x0_q;
    logic [6:0]  y0_q;

    logic        accept;
    logic [7:0]  col;
    logic [6:0]  row;
    logic [14:0] addr;
    logic        last;

    logic        pv_q [ROM_LAT];
    logic [8:0]  px_q [ROM_LAT];
    logic [7:0]  py_q [ROM_LAT];

    logic        in_bounds;
    logic        opaque;

    assign accept = (state_q == ST_IDLE) && start;

    raster_counter u_raster (
        .clk     (clk),
        .rst     (reset),
        .clear_i (accept),
        .en_i    (state_q == ST_RUN),
        .mode_i  (mode_q),
        .col_o   (col),
        .row_o   (row),
        .addr_o  (addr),
        .last_o  (last)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'(ROM_LAT - 1)) state_d = ST_DONE;
                else                            drain_d = drain_q + 2'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            mode_q  <= MODE_SCREEN;
            black_q <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (accept) begin
                mode_q  <= mode;
                black_q <= black;
                x0_q    <= xInit;
                y0_q    <= yInit;
            end
        end
    end

    // Coordinates ride alongside the ROM read so they line up with romData.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pv_q[i] <= 1'b0;
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= (state_q == ST_RUN);
            px_q[0] <= {1'b0, x0_q} + {1'b0, col};
            py_q[0] <= {1'b0, y0_q} + {1'b0, row};
            for (int i = 1; i < ROM_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
        end
    end

    assign in_bounds = (px_q[L] < 9'(SCREEN_W)) && (py_q[L] < 8'(SCREEN_H));
    assign opaque    = black_q || (mode_q == MODE_SCREEN) || (romData != KEY);

    assign romAddr = addr;
    assign x       = px_q[L][7:0];
    assign y       = py_q[L][6:0];
    assign plot    = pv_q[L] && in_bounds && opaque;
    assign colour  = (pv_q[L] && !black_q) ? romData : '0;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_screen_blitter.sv
// tb/tb_screen_blitter.sv - scoreboard bench for screen_blitter
module tb_screen_blitter;

    localparam int         ROM_LAT = 1;
    localparam logic [2:0] KEY     = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic        black;
    logic [7:0]  xInit;
    logic [6:0]  yInit;
    logic [14:0] romAddr;
    logic [2:0]  romData = 3'd0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    screen_blitter #(.ROM_LAT(ROM_LAT), .COLOR_W(3), .KEY(KEY)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .black   (black),
        .xInit   (xInit),
        .yInit   (yInit),
        .romAddr (romAddr),
        .romData (romData),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    logic [2:0] rom [0:19199];
    always @(posedge clk) romData <= rom[romAddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [17:0] exp_q [$];
    int first_c, last_c, min_x, max_x, min_y, max_y, key_cnt;
    int last_x, last_y;

    task automatic fill_rom(input int kind);
        logic [2:0] v;
        for (int i = 0; i < 19200; i++) begin
            v = 3'($urandom_range(0, 7));
            if (v == KEY) v = 3'd2;
            if (kind == 2 || (kind == 1 && (i % 2) == 0)) v = KEY;
            rom[i] = v;
        end
    endtask

    task automatic run_image(input logic m, input logic b, input int x0, input int y0,
                             input int restart_at, input int reset_at,
                             input int exp_plots, input string name);
        int w, h, n, t0, rel, nplot, ndone, done_c;
        int xx, yy;
        logic [2:0]  d;
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [17:0] e;
        w = m ? 40 : 160;
        h = m ? 40 : 120;
        n = w * h;
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                xx = x0 + c;
                yy = y0 + r;
                d  = rom[r * w + c];
                if (xx < 160 && yy < 120 && (b || !m || d != KEY)) begin
                    ex = 8'(xx);
                    ey = 7'(yy);
                    exp_q.push_back({ex, ey, b ? 3'd0 : d});
                end
            end
        end
        nplot = 0; ndone = 0; done_c = -1;
        first_c = -1; last_c = -1; key_cnt = 0;
        min_x = 999; max_x = -1; min_y = 999; max_y = -1;

        @(negedge clk);
        mode = m; black = b; xInit = 8'(x0); yInit = 7'(y0); start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        mode = ~m; black = ~b; xInit = 8'($urandom); yInit = 7'($urandom);

        rel = cyc - t0;
        while (rel <= n + ROM_LAT + 6) begin
            if (rel == 1) check({name, "_busy_first"}, 32'(busy), 1);
            if (rel == n + ROM_LAT) check({name, "_busy_last"}, 32'(busy), 1);
            if (rel == n + ROM_LAT + 1) check({name, "_busy_off"}, 32'(busy), 0);
            if (plot) begin
                nplot++;
                if (first_c < 0) first_c = rel;
                last_c = rel;
                last_x = int'(x); last_y = int'(y);
                if (int'(x) < min_x) min_x = int'(x);
                if (int'(x) > max_x) max_x = int'(x);
                if (int'(y) < min_y) min_y = int'(y);
                if (int'(y) > max_y) max_y = int'(y);
                if (m && colour == KEY) key_cnt++;
                if (exp_q.size() == 0) begin
                    check({name, "_extra_plot"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({name, "_pixel"}, 32'({x, y, colour}), 32'(e));
                end
            end
            if (done) begin
                ndone++;
                done_c = rel;
            end
            if (rel == restart_at) begin
                start = 1'b1; mode = 1'b0; xInit = 8'd0; yInit = 7'd0;
            end
            if (rel == restart_at + 1) start = 1'b0;
            if (rel == reset_at) begin
                reset = 1'b1;
                #1;
                check({name, "_rst_plot"}, 32'(plot), 0);
                check({name, "_rst_busy"}, 32'(busy), 0);
                @(negedge clk);
                reset = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (plot) nplot++;
                    if (done) ndone++;
                end
                check({name, "_rst_noplot"}, 32'(nplot), 32'(reset_at - ROM_LAT));
                check({name, "_rst_nodone"}, 32'(ndone), 0);
                exp_q.delete();
                return;
            end
            @(negedge clk);
            rel = cyc - t0;
        end
        check({name, "_plots"}, 32'(nplot), 32'(exp_plots));
        check({name, "_ndone"}, 32'(ndone), 1);
        check({name, "_done_cyc"}, 32'(done_c), 32'(n + ROM_LAT + 1));
        check({name, "_q_empty"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; black = 1'b0;
        xInit = '0; yInit = '0;
        fill_rom(0);
        repeat (2) @(negedge clk);
        check("rst_addr",   32'(romAddr), 0);
        check("rst_xy",     32'({x, y}), 0);
        check("rst_colour", 32'(colour), 0);
        check("rst_plot",   32'(plot), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        reset = 1'b0;

        run_image(1'b0, 1'b0, 0, 0, -1, -1, 19200, "screen");
        check("screen_first_cyc", 32'(first_c), 2);
        check("screen_last_cyc",  32'(last_c), 19201);
        check("screen_last_xy",   32'(last_x * 1000 + last_y), 159119);

        run_image(1'b1, 1'b0, 150, 100, -1, -1, 200, "clip");
        check("clip_xrange", 32'(min_x * 1000 + max_x), 150159);
        check("clip_yrange", 32'(min_y * 1000 + max_y), 100119);

        fill_rom(1);
        run_image(1'b1, 1'b0, 10, 10, -1, -1, 800, "transp");
        check("transp_no_key", 32'(key_cnt), 0);
        run_image(1'b0, 1'b0, 0, 0, -1, -1, 19200, "screen_key");

        fill_rom(2);
        run_image(1'b1, 1'b1, 20, 30, -1, -1, 1600, "erase");
        check("erase_xrange", 32'(min_x * 1000 + max_x), 20059);
        check("erase_yrange", 32'(min_y * 1000 + max_y), 30069);

        fill_rom(0);
        run_image(1'b1, 1'b0, 5, 5, 500, -1, 1600, "restart");

        run_image(1'b1, 1'b0, 0, 0, -1, 100, 1600, "rstmid");
        run_image(1'b1, 1'b0, 60, 40, -1, -1, 1600, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
